stream_downsize_64to32: RTL and testbench
=========================================

Name: stream_downsize_64to32

Overview:
- Slave-side consumer for the 64-bit valid/ready result stream produced by the pow8 pipeline.
- Accepts one 2*DW-bit word and emits it as two DW-bit beats on a valid/ready master port, low half first by default.
- Sits between the wide arithmetic pipeline and the 32-bit bus-side logic.
- Provides full backpressure on both sides and keeps a wrapping count of words delivered.

Parameters:
- DW, 32, output beat width; input width is 2*DW.
- CNT_W, 16, width of the delivered-word counter.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  input word valid.
- s_ready  out  1  block can take a word this cycle.
- s_data  in  2*DW  input word.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accepts the beat.
- m_data  out  DW  output beat.
- m_last  out  1  high on the second (final) beat of a word.
- word_cnt  out  CNT_W  number of words fully delivered, wraps modulo 2^CNT_W.

Behaviour:
- Reset (asynchronous, active-high):
  - state=EMPTY; holding register cleared to 0; word_cnt=0.
  - Outputs: m_valid=0, m_last=0, m_data=0, s_ready=1 while rst is high and after release.
- Holding register: one 2*DW-bit register, loaded from s_data on each input handshake (s_valid & s_ready).
- States:
  - EMPTY: nothing held.
  - FIRST: held word; first beat is presented.
  - SECOND: held word; second beat is presented.
- m_valid = (state != EMPTY).
- m_data:
  - FIRST presents held[DW-1:0].
  - SECOND presents held[2DW-1:DW].
  - EMPTY drives 0.
- m_last = (state == SECOND).
- s_ready = (state == EMPTY) | (state == SECOND & m_ready).
  - This is a combinational path from m_ready to s_ready and is intentional.
  - Guarantees 2 beats/word sustained throughput with no bubble.
- Transitions:
  - EMPTY: input handshake -> FIRST; otherwise stay.
  - FIRST: m_ready -> SECOND; otherwise hold. Data held stable while m_valid & ~m_ready.
  - SECOND with m_ready: input handshake -> FIRST (new word loaded the same edge); otherwise -> EMPTY.
  - SECOND without m_ready: hold.
- Latency: word accepted at edge N; first beat visible after edge N, i.e. valid in cycle N+1.
- word_cnt increments by 1 on each SECOND-beat handshake (m_valid & m_ready & m_last). It wraps from 2^CNT_W-1 to 0.
- s_data is ignored when s_valid=0, and also when s_ready=0; upstream must hold it.
- Reset asserted mid-word: the held word is discarded, no further beats are emitted, and word_cnt returns to 0.
- Simultaneous m_ready low and s_valid high in FIRST/SECOND: s_ready=0 and nothing is lost.

Optional Feature:
- Macro: STREAM_DOWNSIZE_HI_FIRST_EN.
- Defined:
  - FIRST presents held[2DW-1:DW] and SECOND presents held[DW-1:0] (big-endian beat order).
  - m_last and word_cnt are unchanged.
- Undefined: low half first, as described above.

Test Plan:
- Reset, then s_data=64'h0000_0002_0000_0001 with m_ready=1 -> beats 32'h1 (m_last=0) then 32'h2 (m_last=1) on consecutive cycles; word_cnt=1.
- Three back-to-back words with s_valid and m_ready held high -> 6 beats with no gap; s_ready pulses high on every second-beat cycle; word_cnt=3.
- m_ready=0 for 5 cycles while in FIRST holding 64'hAAAA_BBBB_CCCC_DDDD -> m_data stays 32'hCCCC_DDDD and s_ready=0 throughout; after release, beats are CCCC_DDDD then AAAA_BBBB.
- Assert rst while in SECOND -> m_valid=0, m_last=0 and word_cnt=0 immediately (asynchronous); the next word after release is emitted low half first.
- CNT_W=2, deliver 5 words -> word_cnt sequence 1,2,3,0,1.
- With STREAM_DOWNSIZE_HI_FIRST_EN defined, word 64'h1111_2222_3333_4444 -> beats 32'h1111_2222 then 32'h3333_4444 (m_last=1).

Source files
------------

// File: rtl/stream_downsize_64to32_if.sv
// Valid/ready stream bundle of parameterised width; master drives valid/data, slave drives ready.
interface stream_downsize_64to32_if #(
  parameter int unsigned W = 32
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (output valid, output data, input  ready);
  modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/stream_downsize_64to32.sv
// Splits each 2*DW-bit input word into two DW-bit beats with full backpressure and a delivered-word count.
// Define STREAM_DOWNSIZE_HI_FIRST_EN to emit the upper half first; default is low half first.
module stream_downsize_64to32 #(
  parameter int unsigned DW    = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  stream_downsize_64to32_if.slave  s,
  stream_downsize_64to32_if.master m,
  output logic                     m_last,
  output logic [CNT_W-1:0]         word_cnt
);

  localparam int unsigned WW = 2 * DW;

  localparam logic [1:0] EMPTY  = 2'd0;
  localparam logic [1:0] FIRST  = 2'd1;
  localparam logic [1:0] SECOND = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [WW-1:0] held;
  logic          in_hs;
  logic          last_hs;
  logic [DW-1:0] beat_first;
  logic [DW-1:0] beat_second;

  // Ready in SECOND follows m.ready so a new word loads on the final-beat edge without a bubble.
  assign s.ready = (state == EMPTY) | ((state == SECOND) & m.ready);
  assign in_hs   = s.valid & s.ready;
  assign m.valid = (state != EMPTY);
  assign m_last  = (state == SECOND);
  assign last_hs = m.valid & m.ready & m_last;

`ifdef STREAM_DOWNSIZE_HI_FIRST_EN
  assign beat_first  = held[WW-1:DW];
  assign beat_second = held[DW-1:0];
`else
  assign beat_first  = held[DW-1:0];
  assign beat_second = held[WW-1:DW];
`endif

  always_comb begin
    m.data = '0;
    case (state)
      FIRST:   m.data = beat_first;
      SECOND:  m.data = beat_second;
      default: m.data = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (in_hs) state_nxt = FIRST;
      FIRST:   if (m.ready) state_nxt = SECOND;
      SECOND:  if (m.ready) state_nxt = in_hs ? FIRST : EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        held <= '0;
    else if (in_hs) held <= s.data;
  end

  // Counts whole words: bumps only on the accepted final beat, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          word_cnt <= '0;
    else if (last_hs) word_cnt <= word_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_stream_downsize_64to32.sv
// Scoreboard bench for stream_downsize_64to32: directed words, queue-based beat checking, counter wrap on a CNT_W=2 copy.
`timescale 1ns/1ps
module tb_stream_downsize_64to32;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_last;
  logic        m_last2;
  logic [15:0] word_cnt;
  logic [1:0]  word_cnt2;

  stream_downsize_64to32_if #(.W(64)) si  ();
  stream_downsize_64to32_if #(.W(32)) mi  ();
  stream_downsize_64to32_if #(.W(64)) si2 ();
  stream_downsize_64to32_if #(.W(32)) mi2 ();

  always #5 clk = ~clk;

  assign si2.valid = si.valid;
  assign si2.data  = si.data;
  assign mi2.ready = mi.ready;

  stream_downsize_64to32 #(.DW(32), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .s(si), .m(mi), .m_last(m_last), .word_cnt(word_cnt)
  );

  stream_downsize_64to32 #(.DW(32), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .s(si2), .m(mi2), .m_last(m_last2), .word_cnt(word_cnt2)
  );

  int          vectors     = 0;
  int          miscompares = 0;
  logic [32:0] exp_q[$];
  logic [15:0] exp_cnt     = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] first_beat(input logic [63:0] d);
`ifdef STREAM_DOWNSIZE_HI_FIRST_EN
    return d[63:32];
`else
    return d[31:0];
`endif
  endfunction

  function automatic logic [31:0] second_beat(input logic [63:0] d);
`ifdef STREAM_DOWNSIZE_HI_FIRST_EN
    return d[31:0];
`else
    return d[63:32];
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a word, records its two expected beats, returns 1ns after the accepting edge.
  task automatic send(input logic [63:0] d);
    int budget;
    si.valid = 1'b1;
    si.data  = d;
    exp_q.push_back({1'b0, first_beat(d)});
    exp_q.push_back({1'b1, second_beat(d)});
    budget = 0;
    @(negedge clk);
    while (!si.ready && budget < 100) begin
      budget++;
      @(negedge clk);
    end
    if (!si.ready) check("send_timeout", 64'(si.ready), 64'd1);
    step();
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 100) begin
      budget++;
      @(posedge clk);
    end
    check("drain_left", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
  endtask

  task automatic monitor();
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("word_cnt", 64'(word_cnt), 64'(exp_cnt));
        check("word_cnt_w2", 64'(word_cnt2), 64'(exp_cnt[1:0]));
        if (mi.valid) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL spurious_beat: got data %h with no beat expected at %0t", mi.data, $time);
          end else if (mi.ready) begin
            e = exp_q.pop_front();
            check("beat_data", 64'(mi.data), 64'(e[31:0]));
            check("beat_last", 64'(m_last), 64'(e[32]));
            check("w2_data", 64'(mi2.data), 64'(e[31:0]));
            check("w2_last", 64'(m_last2), 64'(e[32]));
            if (e[32]) exp_cnt = exp_cnt + 16'd1;
          end else begin
            e = exp_q[0];
            check("hold_data", 64'(mi.data), 64'(e[31:0]));
            check("hold_last", 64'(m_last), 64'(e[32]));
          end
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    longint t1;
    longint t3;
    rst      = 1'b1;
    si.valid = 1'b0;
    si.data  = '0;
    mi.ready = 1'b0;
    fork
      monitor();
    join_none

    repeat (2) @(negedge clk);
    check("rst_m_valid", 64'(mi.valid), 64'd0);
    check("rst_m_last",  64'(m_last),   64'd0);
    check("rst_m_data",  64'(mi.data),  64'd0);
    check("rst_s_ready", 64'(si.ready), 64'd1);
    check("rst_cnt",     64'(word_cnt), 64'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_s_ready", 64'(si.ready), 64'd1);
    check("post_rst_m_valid", 64'(mi.valid), 64'd0);

    // Single word, sink always ready
    step();
    mi.ready = 1'b1;
    send(64'h0000_0002_0000_0001);
    si.valid = 1'b0;
    @(negedge clk);
    check("latency_valid", 64'(mi.valid), 64'd1);
    check("latency_last",  64'(m_last),   64'd0);
    check("latency_data",  64'(mi.data),  64'(first_beat(64'h0000_0002_0000_0001)));
    drain();
    check("cnt_after_1", 64'(word_cnt), 64'd1);

    // Three back-to-back words: accepts must be exactly two cycles apart
    step();
    send(64'h0123_4567_89AB_CDEF);
    t1 = longint'($time);
    send(64'hDEAD_BEEF_CAFE_F00D);
    send(64'h1111_2222_3333_4444);
    t3 = longint'($time);
    si.valid = 1'b0;
    check("b2b_spacing", 64'(t3 - t1), 64'd40);
    drain();
    check("cnt_after_b2b", 64'(word_cnt), 64'd4);

    // Stall in FIRST with a pending upstream word
    step();
    mi.ready = 1'b0;
    send(64'hAAAA_BBBB_CCCC_DDDD);
    si.valid = 1'b1;
    si.data  = 64'h0F0F_0F0F_F0F0_F0F0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_data",    64'(mi.data),  64'(first_beat(64'hAAAA_BBBB_CCCC_DDDD)));
      check("stall_s_ready", 64'(si.ready), 64'd0);
    end
    step();
    mi.ready = 1'b1;
    send(64'h0F0F_0F0F_F0F0_F0F0);
    si.valid = 1'b0;
    drain();
    check("cnt_after_stall", 64'(word_cnt), 64'd6);

    // Asynchronous reset while the second beat is presented
    step();
    mi.ready = 1'b0;
    send(64'h5555_6666_7777_8888);
    si.valid = 1'b0;
    mi.ready = 1'b1;
    step();
    mi.ready = 1'b0;
    @(negedge clk);
    check("second_last", 64'(m_last),  64'd1);
    check("second_data", 64'(mi.data), 64'(second_beat(64'h5555_6666_7777_8888)));
    step();
    rst = 1'b1;
    #1;
    check("arst_m_valid", 64'(mi.valid), 64'd0);
    check("arst_m_last",  64'(m_last),   64'd0);
    check("arst_m_data",  64'(mi.data),  64'd0);
    check("arst_s_ready", 64'(si.ready), 64'd1);
    check("arst_cnt",     64'(word_cnt), 64'd0);
    exp_q.delete();
    exp_cnt = '0;
    step();
    step();
    rst      = 1'b0;
    mi.ready = 1'b1;
    send(64'h9999_0000_8888_0001);
    si.valid = 1'b0;
    drain();
    check("cnt_after_arst", 64'(word_cnt), 64'd1);

    // Five more words: CNT_W=2 copy wraps 3 -> 0
    step();
    send(64'h0000_0010_0000_000F);
    send(64'h0000_0020_0000_001F);
    send(64'h0000_0030_0000_002F);
    send(64'h1111_2222_3333_4444);
    send(64'hFFFF_FFFF_0000_0000);
    si.valid = 1'b0;
    drain();
    check("cnt_final",    64'(word_cnt),  64'd6);
    check("cnt_w2_final", 64'(word_cnt2), 64'd2);

    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
